// File: rtl/timer_irq_pkg.sv
// Shared definitions for the timer interrupt collector: register map, FSM states
// and the missed-event counter width.
package timer_irq_pkg;

  localparam logic [2:0] REG_PENDING  = 3'd0;
  localparam logic [2:0] REG_MASK     = 3'd1;
  localparam logic [2:0] REG_PEND_SET = 3'd2;
  localparam logic [2:0] REG_ACTIVE   = 3'd3;
  localparam logic [2:0] REG_MISSED   = 3'd4;

  localparam int MISSED_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } irq_state_e;

endpackage

// File: rtl/irq_sat_cnt.sv
// Saturating event counter; a clear takes priority over a same-cycle increment.
module irq_sat_cnt
  import timer_irq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                clr,
  output logic [MISSED_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Collects timer event pulses into sticky pending bits, masks them and presents
// one interrupt at a time to the core over a req/ack handshake. APB slave.
module timer_irq_ctrl
  import timer_irq_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_SRC        = 2
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_SRC-1:0]        irq_i,
  output logic                      irq_req_o,
  output logic [1:0]                irq_id_o,
  input  logic                      irq_ack_i
);

  logic               wr_en;
  logic               rd_en;
  logic [2:0]         reg_idx;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] pend_nxt;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] mask_nxt;
  logic [NUM_SRC-1:0] w1c_vec;
  logic [NUM_SRC-1:0] pset_vec;
  logic [NUM_SRC-1:0] ack_vec;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] inc_vec;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] id_hot;
  logic [1:0]         low_id;
  logic [1:0]         id;
  logic [1:0]         id_nxt;
  logic               miss_clr;
  irq_state_e         state;
  irq_state_e         state_nxt;
  logic [MISSED_W-1:0] miss_cnt [NUM_SRC];
  logic               unused_bits;

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  assign wr_en   = PSEL && PENABLE && PWRITE;
  assign rd_en   = PSEL && PENABLE && !PWRITE;
  assign reg_idx = PADDR[4:2];

  assign unused_bits = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0], PWDATA[31:NUM_SRC]};

  assign w1c_vec  = (wr_en && reg_idx == REG_PENDING)  ? PWDATA[NUM_SRC-1:0] : '0;
  assign pset_vec = (wr_en && reg_idx == REG_PEND_SET) ? PWDATA[NUM_SRC-1:0] : '0;
  assign mask_nxt = (wr_en && reg_idx == REG_MASK)     ? PWDATA[NUM_SRC-1:0] : mask;
  assign miss_clr = wr_en && (reg_idx == REG_MISSED);

  always_comb begin
    id_hot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      id_hot[i] = (id == 2'(i));
    end
  end

  // Set sources beat clear sources, so a pulse coinciding with a clear is not lost.
  assign ack_vec  = (state == REQ && irq_ack_i) ? id_hot : '0;
  assign set_vec  = irq_i | pset_vec;
  assign clr_vec  = w1c_vec | ack_vec;
  assign pend_nxt = set_vec | (pend & ~clr_vec);
  assign inc_vec  = irq_i & pend & ~clr_vec;
  assign active   = pend & mask;

  always_comb begin
    low_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) low_id = 2'(i);
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend  <= '0;
      mask  <= '0;
      state <= IDLE;
      id    <= '0;
    end else begin
      pend  <= pend_nxt;
      mask  <= mask_nxt;
      state <= state_nxt;
      id    <= id_nxt;
    end
  end

  // Withdrawal looks at next-cycle pending/mask so req drops one cycle after the clear.
  always_comb begin
    state_nxt = state;
    id_nxt    = id;
    case (state)
      IDLE: begin
        if (|active) begin
          state_nxt = REQ;
          id_nxt    = low_id;
        end
      end
      REQ: begin
        if (irq_ack_i || !(|(id_hot & pend_nxt & mask_nxt))) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign irq_req_o = (state == REQ);
  assign irq_id_o  = id;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_miss
    irq_sat_cnt u_cnt (
      .clk   (HCLK),
      .rst   (HRESET),
      .inc   (inc_vec[g]),
      .clr   (miss_clr),
      .count (miss_cnt[g])
    );
  end

  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      case (reg_idx)
        REG_PENDING: PRDATA[NUM_SRC-1:0] = pend;
        REG_MASK:    PRDATA[NUM_SRC-1:0] = mask;
        REG_ACTIVE: begin
          PRDATA[31]  = irq_req_o;
          PRDATA[1:0] = id;
        end
        REG_MISSED: begin
          for (int i = 0; i < NUM_SRC; i++) begin
            PRDATA[i*MISSED_W +: MISSED_W] = miss_cnt[i];
          end
        end
        default: PRDATA = '0;
      endcase
    end
  end

endmodule
